// File: rtl/instruction_fetch_sequencer_if.sv
// ============================================================================
//  Module   : instruction_fetch_sequencer_if
//  Brief    : Fetch-sequencer bundle: instruction memory, execute, control/status
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface instruction_fetch_sequencer_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 26
);
  logic                   mem_req;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic                   mem_ack;
  logic [INSTR_WIDTH-1:0] mem_data;

  logic                   exec_valid;
  logic [INSTR_WIDTH-1:0] exec_instruction;
  logic [ADDR_WIDTH-1:0]  exec_pc;
  logic                   exec_ready;

  logic                   branch_valid;
  logic [ADDR_WIDTH-1:0]  branch_target;
  logic                   halt;

  logic [ADDR_WIDTH-1:0]  instructionPointer;
  logic                   halted;
  logic [15:0]            issue_count;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_data,
    output exec_valid, exec_instruction, exec_pc,
    input  exec_ready,
    input  branch_valid, branch_target, halt,
    output instructionPointer, halted, issue_count
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_data,
    input  exec_valid, exec_instruction, exec_pc,
    output exec_ready,
    output branch_valid, branch_target, halt,
    input  instructionPointer, halted, issue_count
  );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_sequencer.sv
// ============================================================================
//  Module   : instruction_fetch_sequencer
//  Brief    : Soft-CPU front end: fetch over req/ack, issue over valid/ready
//  Revision : 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_sequencer #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    INSTR_WIDTH  = 26,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                          clock,
  input  logic                          reset,
  instruction_fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_ISSUE  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [15:0]           COUNT_ONE = 16'd1;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  ip_q, ip_d;
  logic [ADDR_WIDTH-1:0]  hold_addr_q, hold_addr_d;
  logic                   discard_q, discard_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [15:0]            count_q, count_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_FETCH;
      ip_q        <= RESET_VECTOR;
      hold_addr_q <= RESET_VECTOR;
      discard_q   <= 1'b0;
      instr_q     <= '0;
      pc_q        <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      ip_q        <= ip_d;
      hold_addr_q <= hold_addr_d;
      discard_q   <= discard_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ip_d        = ip_q;
    hold_addr_d = hold_addr_q;
    discard_d   = discard_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    count_d     = count_q;

    unique case (state_q)
      S_FETCH: begin
        if (bus.mem_ack) begin
          if (discard_q || bus.branch_valid) begin
            // Acked word belongs to a redirected stream: drop it and refetch.
            discard_d = 1'b0;
            if (bus.branch_valid) ip_d = bus.branch_target;
            state_d = bus.halt ? S_HALTED : S_FETCH;
          end else begin
            instr_d = bus.mem_data;
            pc_d    = ip_q;
            ip_d    = ip_q + ADDR_ONE;
            state_d = S_ISSUE;
          end
        end else if (bus.branch_valid) begin
          // Request in flight cannot be withdrawn; remember the address it was issued at.
          ip_d      = bus.branch_target;
          discard_d = 1'b1;
          if (!discard_q) hold_addr_d = ip_q;
        end
      end

      S_ISSUE: begin
        if (bus.exec_ready) begin
          count_d = count_q + COUNT_ONE;
          if (bus.branch_valid) ip_d = bus.branch_target;
          state_d = bus.halt ? S_HALTED : S_FETCH;
        end else if (bus.branch_valid) begin
          ip_d    = bus.branch_target;
          state_d = bus.halt ? S_HALTED : S_FETCH;
        end
      end

      S_HALTED: begin
        if (bus.branch_valid) ip_d = bus.branch_target;
        if (!bus.halt) state_d = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase
  end

  assign bus.mem_req            = (state_q == S_FETCH);
  assign bus.mem_addr           = discard_q ? hold_addr_q : ip_q;
  assign bus.exec_valid         = (state_q == S_ISSUE);
  assign bus.exec_instruction   = instr_q;
  assign bus.exec_pc            = pc_q;
  assign bus.instructionPointer = ip_q;
  assign bus.halted             = (state_q == S_HALTED);
  assign bus.issue_count        = count_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_sequencer.sv
// ============================================================================
//  Module   : tb_instruction_fetch_sequencer
//  Brief    : Directed self-checking bench for instruction_fetch_sequencer
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch_sequencer;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;

  instruction_fetch_sequencer_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(26)) bus ();

  instruction_fetch_sequencer #(
    .ADDR_WIDTH  (16),
    .INSTR_WIDTH (26),
    .RESET_VECTOR(16'h0000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [25:0] word(input logic [15:0] a);
    return {10'h2A5, a};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.mem_ack = 1'b0;
    bus.mem_data = '0;
    bus.exec_ready = 1'b0;
    bus.branch_valid = 1'b0;
    bus.branch_target = '0;
    bus.halt = 1'b0;

    // Reset state
    step();
    step();
    reset = 1'b0;
    chk("rst_req",   bus.mem_req, 1);
    chk("rst_addr",  bus.mem_addr, 0);
    chk("rst_ip",    bus.instructionPointer, 0);
    chk("rst_valid", bus.exec_valid, 0);
    chk("rst_instr", bus.exec_instruction, 0);
    chk("rst_pc",    bus.exec_pc, 0);
    chk("rst_count", bus.issue_count, 0);
    chk("rst_halt",  bus.halted, 0);

    // Back-to-back: same-cycle ack, exec_ready held high
    bus.exec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bb_req",   bus.mem_req, 1);
      chk("bb_addr",  bus.mem_addr, i);
      chk("bb_novld", bus.exec_valid, 0);
      bus.mem_ack  = 1'b1;
      bus.mem_data = word(16'(i));
      step();
      bus.mem_ack = 1'b0;
      chk("bb_valid", bus.exec_valid, 1);
      chk("bb_pc",    bus.exec_pc, i);
      chk("bb_instr", bus.exec_instruction, word(16'(i)));
      chk("bb_noreq", bus.mem_req, 0);
      step();
    end
    chk("bb_count", bus.issue_count, 4);
    chk("bb_next",  bus.mem_addr, 4);

    // Delayed ack and stalled execute
    bus.exec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_req",  bus.mem_req, 1);
      chk("wait_addr", bus.mem_addr, 4);
    end
    bus.mem_ack  = 1'b1;
    bus.mem_data = word(16'h0004);
    step();
    bus.mem_ack = 1'b0;
    chk("wait_instr", bus.exec_instruction, word(16'h0004));
    chk("wait_pc",    bus.exec_pc, 4);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stall_valid", bus.exec_valid, 1);
      chk("stall_instr", bus.exec_instruction, word(16'h0004));
      chk("stall_count", bus.issue_count, 4);
    end
    bus.exec_ready = 1'b1;
    step();
    bus.exec_ready = 1'b0;
    chk("stall_done", bus.issue_count, 5);
    chk("stall_next", bus.mem_addr, 5);

    // Branch while fetch of 0x0005 is outstanding
    bus.branch_valid  = 1'b1;
    bus.branch_target = 16'h0040;
    step();
    bus.branch_valid = 1'b0;
    chk("disc_addr_held", bus.mem_addr, 16'h0005);
    chk("disc_ip",        bus.instructionPointer, 16'h0040);
    chk("disc_req",       bus.mem_req, 1);
    bus.mem_ack  = 1'b1;
    bus.mem_data = word(16'h0005);
    step();
    chk("disc_dropped", bus.exec_valid, 0);
    chk("disc_req2",    bus.mem_req, 1);
    chk("disc_newaddr", bus.mem_addr, 16'h0040);
    chk("disc_count",   bus.issue_count, 5);
    bus.mem_data = word(16'h0040);
    step();
    bus.mem_ack = 1'b0;
    chk("disc_valid", bus.exec_valid, 1);
    chk("disc_pc",    bus.exec_pc, 16'h0040);
    chk("disc_instr", bus.exec_instruction, word(16'h0040));
    bus.exec_ready = 1'b1;
    step();
    bus.exec_ready = 1'b0;
    chk("disc_count2", bus.issue_count, 6);
    chk("disc_next",   bus.mem_addr, 16'h0041);

    // Branch on the ack cycle drops the acked word
    bus.mem_ack       = 1'b1;
    bus.mem_data      = word(16'h0041);
    bus.branch_valid  = 1'b1;
    bus.branch_target = 16'h0007;
    step();
    bus.mem_ack      = 1'b0;
    bus.branch_valid = 1'b0;
    chk("ackbr_req",   bus.mem_req, 1);
    chk("ackbr_valid", bus.exec_valid, 0);
    chk("ackbr_addr",  bus.mem_addr, 16'h0007);
    chk("ackbr_count", bus.issue_count, 6);

    // Branch in ISSUE with exec_ready: counted, then redirect
    bus.mem_ack  = 1'b1;
    bus.mem_data = word(16'h0007);
    step();
    bus.mem_ack = 1'b0;
    chk("iss_pc", bus.exec_pc, 16'h0007);
    bus.exec_ready    = 1'b1;
    bus.branch_valid  = 1'b1;
    bus.branch_target = 16'h0100;
    step();
    bus.exec_ready   = 1'b0;
    bus.branch_valid = 1'b0;
    chk("issbr_count", bus.issue_count, 7);
    chk("issbr_req",   bus.mem_req, 1);
    chk("issbr_addr",  bus.mem_addr, 16'h0100);

    // Branch in ISSUE without exec_ready: flushed, not counted
    bus.mem_ack       = 1'b1;
    bus.mem_data      = word(16'h0100);
    bus.branch_valid  = 1'b1;
    bus.branch_target = 16'h0007;
    step();
    bus.branch_valid = 1'b0;
    chk("fl_addr7", bus.mem_addr, 16'h0007);
    bus.mem_data = word(16'h0007);
    step();
    bus.mem_ack = 1'b0;
    chk("fl_valid_in", bus.exec_valid, 1);
    bus.branch_valid  = 1'b1;
    bus.branch_target = 16'h0100;
    step();
    bus.branch_valid = 1'b0;
    chk("fl_valid", bus.exec_valid, 0);
    chk("fl_req",   bus.mem_req, 1);
    chk("fl_addr",  bus.mem_addr, 16'h0100);
    chk("fl_count", bus.issue_count, 7);

    // Halt raised mid-fetch
    bus.halt = 1'b1;
    step();
    chk("h_req_held", bus.mem_req, 1);
    chk("h_not_yet",  bus.halted, 0);
    bus.mem_ack  = 1'b1;
    bus.mem_data = word(16'h0100);
    step();
    bus.mem_ack = 1'b0;
    chk("h_issue", bus.exec_valid, 1);
    chk("h_pc",    bus.exec_pc, 16'h0100);
    bus.exec_ready = 1'b1;
    step();
    bus.exec_ready = 1'b0;
    chk("h_halted", bus.halted, 1);
    chk("h_noreq",  bus.mem_req, 0);
    chk("h_novld",  bus.exec_valid, 0);
    chk("h_count",  bus.issue_count, 8);
    step();
    chk("h_stay",   bus.halted, 1);
    chk("h_stay_q", bus.mem_req, 0);
    bus.halt = 1'b0;
    step();
    chk("h_resume_req",  bus.mem_req, 1);
    chk("h_resume_addr", bus.mem_addr, 16'h0101);
    chk("h_resume_flag", bus.halted, 0);

    // Pointer wrap at 0xFFFF
    bus.mem_ack       = 1'b1;
    bus.mem_data      = word(16'h0101);
    bus.branch_valid  = 1'b1;
    bus.branch_target = 16'hFFFF;
    step();
    bus.branch_valid = 1'b0;
    chk("wr_addr", bus.mem_addr, 16'hFFFF);
    bus.mem_data = word(16'hFFFF);
    step();
    bus.mem_ack = 1'b0;
    chk("wr_pc",    bus.exec_pc, 16'hFFFF);
    chk("wr_instr", bus.exec_instruction, word(16'hFFFF));
    bus.exec_ready = 1'b1;
    step();
    bus.exec_ready = 1'b0;
    chk("wr_next",  bus.mem_addr, 16'h0000);
    chk("wr_count", bus.issue_count, 9);

    // Reset asserted mid-ISSUE
    bus.mem_ack  = 1'b1;
    bus.mem_data = word(16'h0000);
    step();
    bus.mem_ack = 1'b0;
    chk("mr_in_issue", bus.exec_valid, 1);
    reset       = 1'b1;
    bus.mem_ack = 1'b1;
    step();
    reset       = 1'b0;
    bus.mem_ack = 1'b0;
    chk("mr_valid", bus.exec_valid, 0);
    chk("mr_req",   bus.mem_req, 1);
    chk("mr_addr",  bus.mem_addr, 0);
    chk("mr_count", bus.issue_count, 0);
    chk("mr_pc",    bus.exec_pc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
